muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle unsigned multiply/divide unit for the 16-bit CPU. It sits directly upstream of the register file. Its operands come from the register file's two read ports, and it produces a single-cycle write-back strobe, a destination address and 16-bit result data that drive the register file's write port. It uses a fixed-latency iterative datapath: 16 compute cycles plus 1 write-back cycle, with one operation in flight at a time.

## Interface
- No parameters; data width is fixed at 16 and register address width at 3.
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when idle
- op  input  2  00 MUL (low 16 of product), 01 MULH (high 16 of product), 10 DIV (quotient), 11 REM (remainder)
- src_a  input  16  operand A (multiplicand / dividend), from register file read port 1
- src_b  input  16  operand B (multiplier / divisor), from register file read port 2
- dest  input  3  destination register address
- busy  output  1  high while an operation is in progress, including the write-back cycle
- writ_ena  output  1  one-cycle write strobe to the register file
- writ_add  output  3  destination address; valid when writ_ena is high
- writ_dat  output  16  result; valid when writ_ena is high

## Operation
- FSM states:
  - IDLE → CALC when start is high.
  - CALC → WB after the 16th iteration.
  - WB → IDLE unconditionally.
- On accept (IDLE and start high): latch src_a, src_b, op and dest into internal registers, and clear the 4-bit iteration counter.
- After accept, the inputs src_a, src_b, op and dest are don't-care. The caller may change them freely.
- start is ignored in CALC and WB. A request made then is dropped, not queued; the caller must wait for busy low.
- MUL/MULH use shift-add over a 32-bit accumulator, one multiplier bit per cycle, LSB first. After 16 iterations the accumulator equals src_a*src_b exactly, with no overflow.
- DIV/REM use restoring division with a 17-bit partial remainder, one quotient bit per cycle, MSB first.
- Divide by zero gets no special-case logic. The algorithm's natural result applies: quotient 0xFFFF, remainder equals the dividend. No exception flag is raised.
- All arithmetic is unsigned.
- In WB: writ_ena=1, writ_add=latched dest, writ_dat=the selected result.
- Outside WB: writ_ena=0, writ_add=0 and writ_dat=0. The zeros make waveforms deterministic.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, busy 0, writ_ena 0, writ_add 0, writ_dat 0, counter 0, operand/accumulator registers 0.
- Reset asserted mid-operation aborts immediately and asynchronously. No write-back occurs for the aborted operation.
- Let cycle T be the cycle in which start is sampled high in IDLE:
  - T+1..T+16: CALC, busy=1.
  - T+17: WB, busy=1, writ_ena=1.
  - T+18: IDLE, busy=0. A start in T+18 is accepted; no start is accepted earlier.
- Latency from start to writ_ena is exactly 17 cycles for every op and every operand value, including divide by zero.
- Maximum throughput is one operation per 18 cycles.
- writ_ena is high for exactly one cycle per accepted operation.
- All outputs are registered or decoded directly from the state register. No input-to-output combinational path exists.
- The counter wraps 15→0 at the CALC→WB transition. It must not generate a 17th iteration.

## Test plan
- MUL 3×5, dest=2, start at T:
  - busy high T+1..T+17.
  - writ_ena only in T+17, with writ_add=2 and writ_dat=0x000F.
  - busy low at T+18.
- 0xFFFF×0xFFFF, run twice:
  - MUL gives writ_dat=0x0001.
  - MULH gives writ_dat=0xFFFE.
  - The second op is started in the first idle cycle after the first completes, and is accepted.
- DIV 100/7 gives 0x000E; REM 100/7 gives 0x0002. Also cover DIV 0x8000/0x8000 = 0x0001 and REM 0x7FFF/0x8000 = 0x7FFF.
- Divide by zero: DIV 0x1234/0 gives 0xFFFF at T+17; REM 0x1234/0 gives 0x1234 at T+17.
- Start pulsed in T+5 and again in T+17 with different dest/operands. Required: exactly one writ_ena in T+17, carrying the original dest/result, and no second write-back.
- rst_n low in T+8 of a MUL, then released: all outputs 0 immediately, no writ_ena ever for that op. A new start afterwards completes normally 17 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned 16-bit multiply / divide unit feeding the register file write port.
// Latency: result strobed on writ_ena exactly 17 cycles after start is accepted (16 compute + 1 write-back).
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped, caller watches busy.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] src_a,
    input  logic [15:0] src_b,
    input  logic [2:0]  dest,
    output logic        busy,
    output logic        writ_ena,
    output logic [2:0]  writ_add,
    output logic [15:0] writ_dat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [2:0]  dest_q;
    // a_q: multiplicand (MUL/MULH) or dividend shifting out / quotient shifting in (DIV/REM)
    logic [15:0] a_q, a_d;
    // b_q: multiplier shifting right (MUL/MULH) or constant divisor (DIV/REM)
    logic [15:0] b_q, b_d;
    // acc_q: 32-bit product accumulator, or partial remainder in the low 17 bits
    logic [31:0] acc_q, acc_d;

    logic        writ_ena_q;
    logic [2:0]  writ_add_q;
    logic [15:0] writ_dat_q;

    logic [16:0] mul_sum;
    logic [31:0] mul_acc;
    logic [16:0] div_shift;
    logic [17:0] div_diff;
    logic        div_ge;
    logic [16:0] div_rem;
    logic [15:0] div_quo;
    logic [15:0] result_d;

    // One iteration of both datapaths; op_q picks which one updates the registers.
    always_comb begin
        // Shift-add, LSB first: add multiplicand into the upper half, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[31:16]} + {1'b0, (b_q[0] ? a_q : 16'h0000)};
        mul_acc   = {mul_sum, acc_q[15:1]};

        // Restoring division, MSB first: bring in the next dividend bit and try subtracting the divisor.
        // A zero divisor always "fits", which naturally yields quotient 0xFFFF and remainder = dividend.
        div_shift = {acc_q[15:0], a_q[15]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ge    = ~div_diff[17];
        div_rem   = div_ge ? div_diff[16:0] : div_shift;
        div_quo   = {a_q[14:0], div_ge};

        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (op_q[1]) begin
            a_d   = div_quo;
            acc_d = {15'h0000, div_rem};
        end else begin
            b_d   = {1'b0, b_q[15:1]};
            acc_d = mul_acc;
        end

        // Result as it will stand after the current iteration, captured on the last one.
        result_d = 16'h0000;
        case (op_q)
            OP_MUL:  result_d = mul_acc[15:0];
            OP_MULH: result_d = mul_acc[31:16];
            OP_DIV:  result_d = div_quo;
            OP_REM:  result_d = div_rem[15:0];
            default: result_d = 16'h0000;
        endcase
    end

    // Control FSM with registered write-back outputs; outputs are zero outside the write-back cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 2'b00;
            dest_q     <= 3'd0;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            acc_q      <= 32'h0000_0000;
            writ_ena_q <= 1'b0;
            writ_add_q <= 3'd0;
            writ_dat_q <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CALC;
                        a_q     <= src_a;
                        b_q     <= src_b;
                        op_q    <= op;
                        dest_q  <= dest;
                        cnt_q   <= 4'd0;
                        acc_q   <= 32'h0000_0000;
                    end
                end
                ST_CALC: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                    // Counter wraps 15->0 on the last iteration, so there is never a 17th step.
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q    <= ST_WB;
                        writ_ena_q <= 1'b1;
                        writ_add_q <= dest_q;
                        writ_dat_q <= result_d;
                    end
                end
                ST_WB: begin
                    state_q    <= ST_IDLE;
                    writ_ena_q <= 1'b0;
                    writ_add_q <= 3'd0;
                    writ_dat_q <= 16'h0000;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    writ_ena_q <= 1'b0;
                    writ_add_q <= 3'd0;
                    writ_dat_q <= 16'h0000;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign writ_ena = writ_ena_q;
    assign writ_add = writ_add_q;
    assign writ_dat = writ_dat_q;

endmodule
